// File: rtl/pio_irq_servicer.sv
// Autonomous Avalon-MM master for an edge-capture input PIO: programs the irq
// mask, then on irq reads/clears the captured edges and streams {edges, levels}.
module pio_irq_servicer #(
  parameter int               WIDTH     = 6,
  parameter logic [WIDTH-1:0] MASK_INIT = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic [2:0]       address,
  output logic             chipselect,
  output logic             write_n,
  output logic [31:0]      writedata,
  input  logic [31:0]      readdata,
  input  logic             irq,
  input  logic [WIDTH-1:0] cfg_mask,
  input  logic             cfg_mask_wr,
  output logic             event_valid,
  input  logic             event_ready,
  output logic [WIDTH-1:0] event_edges,
  output logic [WIDTH-1:0] event_level,
  output logic             busy,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_MASK  = 3'd1,
    RD_CAP_A = 3'd2,
    RD_CAP_D = 3'd3,
    CLR      = 3'd4,
    RD_PIN_A = 3'd5,
    RD_PIN_D = 3'd6,
    EMIT     = 3'd7
  } state_e;

  state_e           state_q, state_d;
  logic             mask_pending_q, mask_pending_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edges_q, edges_d;
  logic [WIDTH-1:0] ev_edges_q, ev_edges_d;
  logic [WIDTH-1:0] ev_level_q, ev_level_d;

  // Slave readdata is one cycle late; the upper bits beyond WIDTH carry nothing.
  if (WIDTH < 32) begin : g_unused_rd
    logic unused_readdata_hi;
    assign unused_readdata_hi = ^readdata[31:WIDTH];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      mask_pending_q <= 1'b1;
      mask_q         <= MASK_INIT;
      edges_q        <= '0;
      ev_edges_q     <= '0;
      ev_level_q     <= '0;
    end else begin
      state_q        <= state_d;
      mask_pending_q <= mask_pending_d;
      mask_q         <= mask_d;
      edges_q        <= edges_d;
      ev_edges_q     <= ev_edges_d;
      ev_level_q     <= ev_level_d;
    end
  end

  // Event stream: event_valid is held with stable data until a clock where
  // event_valid && event_ready; that clock is the transfer.
  always_comb begin
    state_d        = state_q;
    mask_pending_d = mask_pending_q;
    mask_d         = mask_q;
    edges_d        = edges_q;
    ev_edges_d     = ev_edges_q;
    ev_level_d     = ev_level_q;

    if (cfg_mask_wr) begin
      mask_d         = cfg_mask;
      mask_pending_d = 1'b1;
    end else if (state_q == WR_MASK) begin
      mask_pending_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (mask_pending_q)  state_d = WR_MASK;
        else if (irq)        state_d = RD_CAP_A;
      end
      WR_MASK:  state_d = IDLE;
      RD_CAP_A: state_d = RD_CAP_D;
      RD_CAP_D: begin
        edges_d = readdata[WIDTH-1:0];
        state_d = (readdata[WIDTH-1:0] == '0) ? IDLE : CLR;
      end
      CLR:      state_d = RD_PIN_A;
      RD_PIN_A: state_d = RD_PIN_D;
      RD_PIN_D: begin
        ev_edges_d = edges_q;
        ev_level_d = readdata[WIDTH-1:0];
        state_d    = EMIT;
      end
      EMIT: begin
        if (event_ready) state_d = IDLE;
      end
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 3'd0;
    writedata  = '0;
    case (state_q)
      WR_MASK: begin
        chipselect            = 1'b1;
        write_n               = 1'b0;
        address               = 3'd2;
        writedata[WIDTH-1:0]  = mask_q;
      end
      RD_CAP_A, RD_CAP_D: begin
        chipselect = 1'b1;
        address    = 3'd3;
      end
      CLR: begin
        chipselect            = 1'b1;
        write_n               = 1'b0;
        address               = 3'd3;
        writedata[WIDTH-1:0]  = edges_q;
      end
      RD_PIN_A, RD_PIN_D: begin
        chipselect = 1'b1;
      end
      default: ;
    endcase
  end

  assign event_valid = (state_q == EMIT);
  assign event_edges = ev_edges_q;
  assign event_level = ev_level_q;
  assign busy        = (state_q != IDLE);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_pio_irq_servicer.sv
// Bench for pio_irq_servicer: behavioural edge-capture PIO slave, directed
// stimulus, and negedge monitors popping expected bus writes and events.
module tb_pio_irq_servicer;
  localparam int WIDTH = 6;

  localparam logic [2:0] S_IDLE = 3'd0, S_CLR = 3'd4, S_RD_PIN_A = 3'd5, S_EMIT = 3'd7;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [2:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [31:0]      readdata;
  logic             irq;
  logic [WIDTH-1:0] cfg_mask;
  logic             cfg_mask_wr;
  logic             event_valid;
  logic             event_ready;
  logic [WIDTH-1:0] event_edges;
  logic [WIDTH-1:0] event_level;
  logic             busy;
  logic [2:0]       dbg_state;

  int passed = 0;
  int total  = 0;

  logic [34:0]        exp_wr_q[$];
  logic [2*WIDTH-1:0] exp_ev_q[$];

  always #5 clk = ~clk;

  pio_irq_servicer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq),
    .cfg_mask(cfg_mask), .cfg_mask_wr(cfg_mask_wr), .event_valid(event_valid),
    .event_ready(event_ready), .event_edges(event_edges), .event_level(event_level),
    .busy(busy), .dbg_state(dbg_state)
  );

  // Edge-capture PIO slave model with registered readdata and bit-clearing capture.
  logic [31:0]      s_mask = '0;
  logic [31:0]      s_cap  = '0;
  logic [31:0]      rd_q   = '0;
  logic [31:0]      cap_clr;
  logic [WIDTH-1:0] pins   = '0;
  logic [WIDTH-1:0] inj    = '0;
  logic             irq_force = 1'b0;

  assign cap_clr  = (chipselect && !write_n && address == 3'd3) ? writedata : 32'h0;
  assign readdata = rd_q;
  assign irq      = (|(s_cap[WIDTH-1:0] & s_mask[WIDTH-1:0])) | irq_force;

  always @(posedge clk) begin
    s_cap <= (s_cap & ~cap_clr) | 32'(inj);
    if (chipselect && !write_n && address == 3'd2) s_mask <= writedata;
    case (address)
      3'd0:    rd_q <= {26'h2AAAAAA, pins};
      3'd2:    rd_q <= s_mask;
      3'd3:    rd_q <= {26'h1555555, s_cap[WIDTH-1:0]};
      default: rd_q <= '0;
    endcase
  end

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  always @(negedge clk) begin
    if (reset_n && chipselect && !write_n) begin
      if (exp_wr_q.size() == 0) begin
        total++;
        $display("FAIL unexp_write: got addr=%0d data=0x%0h expected none", address, writedata);
      end else begin
        check("bus_write", {address, writedata}, exp_wr_q.pop_front());
      end
    end
    if (reset_n && event_valid && event_ready) begin
      if (exp_ev_q.size() == 0) begin
        total++;
        $display("FAIL unexp_event: got edges=0x%0h level=0x%0h expected none", event_edges, event_level);
      end else begin
        check("event", {event_edges, event_level}, exp_ev_q.pop_front());
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic inject(input logic [WIDTH-1:0] v);
    inj = v;
    tick();
    inj = '0;
  endtask

  task automatic wait_state(input logic [2:0] st, input string name);
    int n;
    n = 0;
    while (dbg_state !== st && n < 50) begin
      tick();
      n++;
    end
    check(name, dbg_state, st);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_wr_q.size() != 0 || exp_ev_q.size() != 0 || busy) && n < 200) begin
      tick();
      n++;
    end
    check(name, exp_wr_q.size() + exp_ev_q.size() + 32'(busy), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cs"},     chipselect,  1'b0);
    check({tag, "_wn"},     write_n,     1'b1);
    check({tag, "_addr"},   address,     3'd0);
    check({tag, "_wdata"},  writedata,   32'h0);
    check({tag, "_valid"},  event_valid, 1'b0);
    check({tag, "_edges"},  event_edges, 6'h0);
    check({tag, "_level"},  event_level, 6'h0);
    check({tag, "_busy"},   busy,        1'b0);
    check({tag, "_state"},  dbg_state,   S_IDLE);
  endtask

  initial begin
    int n;
    reset_n     = 1'b0;
    cfg_mask    = '0;
    cfg_mask_wr = 1'b0;
    event_ready = 1'b1;
    repeat (3) tick();
    check_reset_outputs("rst");

    // Reset release: one IDLE cycle, one WR_MASK cycle with MASK_INIT, then idle.
    exp_wr_q.push_back({3'd2, 32'h3F});
    reset_n = 1'b1;
    check("rel_state", dbg_state, S_IDLE);
    check("rel_busy", busy, 1'b0);
    tick();
    check("mask_cs", chipselect, 1'b1);
    check("mask_wn", write_n, 1'b0);
    check("mask_addr", address, 3'd2);
    check("mask_wdata", writedata, 32'h3F);
    check("mask_busy", busy, 1'b1);
    tick();
    check("post_mask_cs", chipselect, 1'b0);
    check("post_mask_busy", busy, 1'b0);

    // Basic service: edges 0x05, pins 0x3A, latency 6 clocks to valid.
    pins = 6'h3A;
    exp_wr_q.push_back({3'd3, 32'h05});
    exp_ev_q.push_back({6'h05, 6'h3A});
    inject(6'h05);
    check("irq_seen", irq, 1'b1);
    n = 0;
    while (!event_valid && n < 50) begin
      tick();
      n++;
    end
    check("latency", n, 6);
    tick();
    check("valid_drop", event_valid, 1'b0);
    check("edges_hold", event_edges, 6'h05);
    check("level_hold", event_level, 6'h3A);
    check("cap_cleared", s_cap, 32'h0);

    // Backpressure: event held 10 cycles, new irq ignored, then serviced.
    event_ready = 1'b0;
    pins = 6'h15;
    exp_wr_q.push_back({3'd3, 32'h12});
    exp_ev_q.push_back({6'h12, 6'h15});
    inject(6'h12);
    wait_state(S_EMIT, "bp_reach_emit");
    for (int i = 0; i < 10; i++) begin
      check("bp_hold", {event_valid, event_edges, event_level}, {1'b1, 6'h12, 6'h15});
      if (i == 0) inj = 6'h01;
      tick();
      inj = '0;
    end
    check("bp_irq_pending", irq, 1'b1);
    check("bp_still_emit", dbg_state, S_EMIT);
    exp_wr_q.push_back({3'd3, 32'h01});
    exp_ev_q.push_back({6'h01, 6'h15});
    event_ready = 1'b1;
    wait_drain("bp_drain");

    // Spurious irq: capture reads zero, back to IDLE with no write and no event.
    irq_force = 1'b1;
    tick();
    irq_force = 1'b0;
    n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    check("spur_busy_cycles", n, 2);
    check("spur_state", dbg_state, S_IDLE);
    repeat (3) tick();
    check("spur_no_valid", event_valid, 1'b0);

    // Mask update during RD_PIN_A with another edge pending: event, mask, then service.
    pins = 6'h2D;
    exp_wr_q.push_back({3'd3, 32'h04});
    exp_ev_q.push_back({6'h04, 6'h2D});
    exp_wr_q.push_back({3'd2, 32'h03});
    exp_wr_q.push_back({3'd3, 32'h02});
    exp_ev_q.push_back({6'h02, 6'h2D});
    inject(6'h04);
    wait_state(S_RD_PIN_A, "cfg_reach_rdpin");
    inj = 6'h02;
    cfg_mask = 6'h03;
    cfg_mask_wr = 1'b1;
    tick();
    inj = '0;
    cfg_mask_wr = 1'b0;
    wait_drain("cfg_drain");
    check("cfg_slave_mask", s_mask, 32'h03);

    // Reset during CLR: immediate reset outputs, then mask rewrite and normal service.
    inject(6'h01);
    wait_state(S_CLR, "rst_reach_clr");
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_wr_q.push_back({3'd2, 32'h3F});
    exp_wr_q.push_back({3'd3, 32'h01});
    exp_ev_q.push_back({6'h01, 6'h2D});
    tick();
    tick();
    reset_n = 1'b1;
    wait_drain("rst_drain");
    check("final_cap", s_cap, 32'h0);
    check("final_mask", s_mask, 32'h3F);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
